// File: rtl/flipflop_pkg.sv
// Shared constants and state encoding for the memory-matching game.
package flipflop_pkg;

    localparam logic [3:0] NO_SEL  = 4'hF;
    localparam logic [3:0] VAL_MIN = 4'd1;
    localparam logic [3:0] VAL_MAX = 4'd14;
    localparam int         POS_W   = 4;

    typedef enum logic [2:0] {
        IDLE_A = 3'd0,
        WAIT_B = 3'd1,
        SHOW   = 3'd2,
        CLEAR  = 3'd3,
        DONE   = 3'd4
    } turn_state_t;

endpackage

// File: rtl/turn_controller_show_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module show_timer #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/turn_controller.sv
// Turn sequencing for the memory-matching game: two picks, a timed reveal, then a one-cycle clear.
// Optional TURN_TWO_PLAYER_EN adds the player / score_b ports for alternating two-player play.
module turn_controller
    import flipflop_pkg::*;
#(
    parameter int NUM_PAIRS   = 8,
    parameter int SHOW_CYCLES = 25_000_000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        pick_valid,
    input  logic [3:0]  pick_pos,
    input  logic [3:0]  pick_value,
    output logic [3:0]  selectedA,
    output logic [3:0]  selectedB,
    output logic        ready,
    output logic        pick_err,
    output logic        match_pulse,
    output logic        miss_pulse,
    output logic [15:0] removed_mask,
    output logic [3:0]  pairs_left,
    output logic [7:0]  turns,
    output logic [3:0]  score,
    output logic        game_over
`ifdef TURN_TWO_PLAYER_EN
    ,
    output logic        player,
    output logic [3:0]  score_b
`endif
);

    localparam int              TW        = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [TW-1:0]   TLOAD     = TW'(SHOW_CYCLES - 1);
    localparam logic [4:0]      POS_LIMIT = 5'(2 * NUM_PAIRS);

    turn_state_t      state;
    logic [POS_W-1:0] pos_a;
    logic [POS_W-1:0] pos_b;
    logic             is_match;
    logic             timer_done;
    logic             pick_ok;
    logic             timer_load;

    // A pick is legal only on an in-range, still-present position with a legal value,
    // and the second pick may not reuse the first position.
    always_comb begin
        pick_ok = 1'b1;
        if ({1'b0, pick_pos} >= POS_LIMIT)                   pick_ok = 1'b0;
        if (removed_mask[pick_pos])                          pick_ok = 1'b0;
        if (pick_value < VAL_MIN || pick_value > VAL_MAX)    pick_ok = 1'b0;
        if (state == WAIT_B && pick_pos == pos_a)            pick_ok = 1'b0;
    end

    assign ready      = (state == IDLE_A) || (state == WAIT_B);
    assign game_over  = (state == DONE);
    assign timer_load = (state == WAIT_B) && pick_valid && pick_ok;

    show_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (timer_load),
        .load_val (TLOAD),
        .done     (timer_done)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE_A;
            pos_a        <= '0;
            pos_b        <= '0;
            is_match     <= 1'b0;
            selectedA    <= NO_SEL;
            selectedB    <= NO_SEL;
            pick_err     <= 1'b0;
            match_pulse  <= 1'b0;
            miss_pulse   <= 1'b0;
            removed_mask <= '0;
            pairs_left   <= 4'(NUM_PAIRS);
            turns        <= '0;
            score        <= '0;
`ifdef TURN_TWO_PLAYER_EN
            player       <= 1'b0;
            score_b      <= '0;
`endif
        end else begin
            pick_err    <= 1'b0;
            match_pulse <= 1'b0;
            miss_pulse  <= 1'b0;
            case (state)
                IDLE_A: begin
                    if (pick_valid) begin
                        if (pick_ok) begin
                            pos_a     <= pick_pos;
                            selectedA <= pick_value;
                            state     <= WAIT_B;
                        end else begin
                            pick_err <= 1'b1;
                        end
                    end
                end
                WAIT_B: begin
                    if (pick_valid) begin
                        if (pick_ok) begin
                            pos_b     <= pick_pos;
                            selectedB <= pick_value;
                            is_match  <= (selectedA == pick_value);
                            state     <= SHOW;
                        end else begin
                            pick_err <= 1'b1;
                        end
                    end
                end
                SHOW: begin
                    // The whole commit is registered here so it appears during the CLEAR cycle.
                    if (timer_done) begin
                        selectedA <= NO_SEL;
                        selectedB <= NO_SEL;
                        state     <= CLEAR;
                        if (turns != 8'hFF) turns <= turns + 8'd1;
                        if (is_match) begin
                            removed_mask <= removed_mask | (16'd1 << pos_a) | (16'd1 << pos_b);
                            pairs_left   <= pairs_left - 4'd1;
                            match_pulse  <= 1'b1;
`ifdef TURN_TWO_PLAYER_EN
                            if (player) score_b <= score_b + 4'd1;
                            else        score   <= score + 4'd1;
`else
                            score <= score + 4'd1;
`endif
                        end else begin
                            miss_pulse <= 1'b1;
`ifdef TURN_TWO_PLAYER_EN
                            player <= ~player;
`endif
                        end
                    end
                end
                CLEAR: begin
                    state <= (pairs_left == 4'd0) ? DONE : IDLE_A;
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller with NUM_PAIRS=2, SHOW_CYCLES=4.
module tb_turn_controller;

    localparam int NP = 2;
    localparam int SC = 4;
`ifdef TURN_TWO_PLAYER_EN
    localparam logic [3:0] SCORE_LAST = 4'd1;
`else
    localparam logic [3:0] SCORE_LAST = 4'd2;
`endif

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        pick_valid = 1'b0;
    logic [3:0]  pick_pos = '0;
    logic [3:0]  pick_value = '0;
    logic [3:0]  selectedA, selectedB;
    logic        ready, pick_err, match_pulse, miss_pulse, game_over;
    logic [15:0] removed_mask;
    logic [3:0]  pairs_left, score;
    logic [7:0]  turns;
`ifdef TURN_TWO_PLAYER_EN
    logic        player;
    logic [3:0]  score_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    turn_controller #(.NUM_PAIRS(NP), .SHOW_CYCLES(SC)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .pick_valid   (pick_valid),
        .pick_pos     (pick_pos),
        .pick_value   (pick_value),
        .selectedA    (selectedA),
        .selectedB    (selectedB),
        .ready        (ready),
        .pick_err     (pick_err),
        .match_pulse  (match_pulse),
        .miss_pulse   (miss_pulse),
        .removed_mask (removed_mask),
        .pairs_left   (pairs_left),
        .turns        (turns),
        .score        (score),
        .game_over    (game_over)
`ifdef TURN_TWO_PLAYER_EN
        ,
        .player       (player),
        .score_b      (score_b)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  sel_a;
        logic [3:0]  sel_b;
        logic        rdy;
        logic        err;
        logic        mp;
        logic        mi;
        logic [15:0] mask;
        logic [3:0]  pairs;
        logic [7:0]  trn;
        logic [3:0]  scr;
        logic        over;
    } outs_t;

    typedef struct {
        logic       pv;
        logic [3:0] pos;
        logic [3:0] val;
        outs_t      exp;
    } vec_t;

    function automatic outs_t sample();
        outs_t o;
        o = '{selectedA, selectedB, ready, pick_err, match_pulse, miss_pulse,
              removed_mask, pairs_left, turns, score, game_over};
        return o;
    endfunction

    function automatic vec_t mk(logic pv, logic [3:0] pos, logic [3:0] val,
                                logic [3:0] sa, logic [3:0] sb, logic rdy, logic err,
                                logic mp, logic mi, logic [15:0] mask, logic [3:0] pairs,
                                logic [7:0] trn, logic [3:0] scr, logic over);
        vec_t v;
        v.pv  = pv;
        v.pos = pos;
        v.val = val;
        v.exp = '{sa, sb, rdy, err, mp, mi, mask, pairs, trn, scr, over};
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic pv, logic [3:0] pos, logic [3:0] val);
        pick_valid = pv;
        pick_pos   = pos;
        pick_value = val;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(1'b0, 4'd0, 4'd0);
        tick();
        tick();
        resetn = 1'b1;
    endtask

    outs_t reset_exp;
    vec_t  vecs[$];
    logic  saw_match;

    initial begin
        reset_exp = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 4'd2, 8'd0, 4'd0, 1'b0};

        // Full game: match, illegal picks, miss, final match, then DONE.
        vecs.push_back(mk(1, 4'd0, 4'd3,  4'd3, 4'hF, 1, 0, 0, 0, 16'h0000, 4'd2, 8'd0, 4'd0, 0));
        vecs.push_back(mk(1, 4'd0, 4'd3,  4'd3, 4'hF, 1, 1, 0, 0, 16'h0000, 4'd2, 8'd0, 4'd0, 0));
        vecs.push_back(mk(1, 4'd1, 4'd3,  4'd3, 4'd3, 0, 0, 0, 0, 16'h0000, 4'd2, 8'd0, 4'd0, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd3, 4'd3, 0, 0, 0, 0, 16'h0000, 4'd2, 8'd0, 4'd0, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd3, 4'd3, 0, 0, 0, 0, 16'h0000, 4'd2, 8'd0, 4'd0, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd3, 4'd3, 0, 0, 0, 0, 16'h0000, 4'd2, 8'd0, 4'd0, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'hF, 4'hF, 0, 0, 1, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd0, 4'd3,  4'hF, 4'hF, 1, 0, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd1, 4'd3,  4'hF, 4'hF, 1, 1, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd2, 4'd0,  4'hF, 4'hF, 1, 1, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd2, 4'd15, 4'hF, 4'hF, 1, 1, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd4, 4'd5,  4'hF, 4'hF, 1, 1, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd2, 4'd5,  4'd5, 4'hF, 1, 0, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd3, 4'd7,  4'd5, 4'd7, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(1, 4'd2, 4'd5,  4'd5, 4'd7, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd5, 4'd7, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd5, 4'd7, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd1, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'hF, 4'hF, 0, 0, 0, 1, 16'h0003, 4'd1, 8'd2, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'hF, 4'hF, 1, 0, 0, 0, 16'h0003, 4'd1, 8'd2, 4'd1, 0));
        vecs.push_back(mk(1, 4'd2, 4'd5,  4'd5, 4'hF, 1, 0, 0, 0, 16'h0003, 4'd1, 8'd2, 4'd1, 0));
        vecs.push_back(mk(1, 4'd3, 4'd5,  4'd5, 4'd5, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd2, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd5, 4'd5, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd2, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd5, 4'd5, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd2, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'd5, 4'd5, 0, 0, 0, 0, 16'h0003, 4'd1, 8'd2, 4'd1, 0));
        vecs.push_back(mk(0, 4'd0, 4'd0,  4'hF, 4'hF, 0, 0, 1, 0, 16'h000F, 4'd0, 8'd3, SCORE_LAST, 0));
        vecs.push_back(mk(1, 4'd0, 4'd1,  4'hF, 4'hF, 0, 0, 0, 0, 16'h000F, 4'd0, 8'd3, SCORE_LAST, 1));
        vecs.push_back(mk(1, 4'd0, 4'd1,  4'hF, 4'hF, 0, 0, 0, 0, 16'h000F, 4'd0, 8'd3, SCORE_LAST, 1));

        do_reset();
        check("reset_state", 64'(sample()), 64'(reset_exp));

        foreach (vecs[i]) begin
            drive(vecs[i].pv, vecs[i].pos, vecs[i].val);
            tick();
            check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].exp));
        end

        // Reset landing in the second SHOW cycle, with a pick offered during reset.
        do_reset();
        drive(1, 4'd0, 4'd3); tick();
        drive(1, 4'd1, 4'd3); tick();
        drive(0, 4'd0, 4'd0); tick();
        resetn = 1'b0;
        drive(1, 4'd2, 4'd5);
        tick();
        check("reset_mid_show", 64'(sample()), 64'(reset_exp));
        resetn = 1'b1;
        drive(0, 4'd0, 4'd0);
        saw_match = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (match_pulse) saw_match = 1'b1;
        end
        check("no_commit_after_reset", 64'({saw_match, removed_mask, turns, selectedA}),
              64'({1'b0, 16'h0000, 8'd0, 4'hF}));

        // Second pick to CLEAR entry takes exactly SHOW_CYCLES cycles.
        drive(1, 4'd0, 4'd9); tick();
        drive(1, 4'd2, 4'd9); tick();
        drive(0, 4'd0, 4'd0);
        for (int k = 1; k < SC; k++) tick();
        check("show_last_cycle", 64'({selectedB, match_pulse}), 64'({4'd9, 1'b0}));
        tick();
        check("clear_cycle", 64'({selectedA, selectedB, match_pulse, removed_mask}),
              64'({4'hF, 4'hF, 1'b1, 16'h0005}));

`ifdef TURN_TWO_PLAYER_EN
        // Miss toggles to player 1, who then scores a match.
        do_reset();
        drive(1, 4'd0, 4'd3); tick();
        drive(1, 4'd2, 4'd5); tick();
        drive(0, 4'd0, 4'd0);
        for (int k = 0; k < SC; k++) tick();
        check("tp_after_miss", 64'({player, miss_pulse}), 64'({1'b1, 1'b1}));
        tick();
        drive(1, 4'd0, 4'd3); tick();
        drive(1, 4'd1, 4'd3); tick();
        drive(0, 4'd0, 4'd0);
        for (int k = 0; k < SC; k++) tick();
        check("tp_after_match", 64'({player, score_b, score, match_pulse}),
              64'({1'b1, 4'd1, 4'd0, 1'b1}));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
